// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R1W register file with bypass, written map and clear sweep
module regfile_param #(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int RD_REG   = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic [DEPTH-1:0] written
);

    localparam logic [AW:0]       DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]     LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [DEPTH-1:0]  ZERO_MASK = (ZERO_REG != 0) ? DEPTH'(1) : '0;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_next;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic             wr_acc;
    logic [WIDTH-1:0] rd_val1, rd_val2;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign busy    = (state == SWEEP);
    assign wr_acc  = wr_en && !busy && !clr_req && addr_ok(wr_addr);
    assign written = written_q & ~ZERO_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clr_req) state_next = SWEEP;
            SWEEP:   if (ptr == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The sweep owns the array while busy; writes are rejected by wr_acc then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            written_q <= '0;
            ptr       <= '0;
        end else if (state == SWEEP) begin
            mem[ptr]       <= '0;
            written_q[ptr] <= 1'b0;
            ptr            <= (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
        end else begin
            if (clr_req) begin
                ptr <= '0;
            end
            if (wr_acc) begin
                mem[wr_addr]       <= wr_data;
                written_q[wr_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_val1 = '0;
        if (addr_ok(rd_addr1)) begin
            if ((BYPASS != 0) && wr_acc && (rd_addr1 == wr_addr)) begin
                rd_val1 = wr_data;
            end else begin
                rd_val1 = mem[rd_addr1];
            end
        end
    end

    always_comb begin
        rd_val2 = '0;
        if (addr_ok(rd_addr2)) begin
            if ((BYPASS != 0) && wr_acc && (rd_addr2 == wr_addr)) begin
                rd_val2 = wr_data;
            end else begin
                rd_val2 = mem[rd_addr2];
            end
        end
    end

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] rd_q1, rd_q2;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q1 <= '0;
                    rd_q2 <= '0;
                end else begin
                    rd_q1 <= rd_val1;
                    rd_q2 <= rd_val2;
                end
            end
            assign rd_data1 = rd_q1;
            assign rd_data2 = rd_q2;
        end else begin : g_rd_comb
            assign rd_data1 = rd_val1;
            assign rd_data2 = rd_val2;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param across four configurations
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;

    logic       rst_n, rst_n6;
    logic [2:0] ra1, ra2, wa;
    logic       we, clr;
    logic [3:0] wd;

    logic [3:0] rd1_d, rd2_d, rd1_a, rd2_a, rd1_6, rd2_6;
    logic       busy_d, busy_a, busy_6;
    logic [7:0] written_d, written_a;
    logic [5:0] written_6;

    logic [3:0]  r_ra1, r_ra2, r_wa;
    logic        r_we, r_clr, r_busy;
    logic [7:0]  r_wd, r_rd1, r_rd2;
    logic [15:0] r_written;

    regfile_param u_def (
        .clk(clk), .rst_n(rst_n), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(rd1_d), .rd_data2(rd2_d), .wr_en(we), .wr_addr(wa),
        .wr_data(wd), .clr_req(clr), .busy(busy_d), .written(written_d)
    );

    regfile_param #(.ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst_n(rst_n), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(rd1_a), .rd_data2(rd2_a), .wr_en(we), .wr_addr(wa),
        .wr_data(wd), .clr_req(clr), .busy(busy_a), .written(written_a)
    );

    regfile_param #(.DEPTH(6)) u_d6 (
        .clk(clk), .rst_n(rst_n6), .rd_addr1(ra1), .rd_addr2(ra2),
        .rd_data1(rd1_6), .rd_data2(rd2_6), .wr_en(we), .wr_addr(wa),
        .wr_data(wd), .clr_req(clr), .busy(busy_6), .written(written_6)
    );

    regfile_param #(.WIDTH(8), .DEPTH(16), .RD_REG(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .rd_addr1(r_ra1), .rd_addr2(r_ra2),
        .rd_data1(r_rd1), .rd_data2(r_rd2), .wr_en(r_we), .wr_addr(r_wa),
        .wr_data(r_wd), .clr_req(r_clr), .busy(r_busy), .written(r_written)
    );

    task automatic test_reset();
        rst_n = 1'b0; rst_n6 = 1'b0;
        ra1 = 3'd3; ra2 = 3'd0; wa = '0; we = 1'b0; wd = '0; clr = 1'b0;
        r_ra1 = '0; r_ra2 = '0; r_wa = '0; r_we = 1'b0; r_wd = '0; r_clr = 1'b0;
        @(negedge clk); #1;
        checks++; if (busy_d !== 1'b0 || busy_6 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0/0", busy_d, busy_6); end
        checks++; if (written_d !== 8'h00 || written_6 !== 6'h00) begin errors++; $display("FAIL reset_written got %h/%h exp 0/0", written_d, written_6); end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL reset_rd1 got %h exp %h", rd1_d, e); end
        e = exp_q.pop_front();
        checks++; if (r_rd2 !== e) begin errors++; $display("FAIL reset_rr_rd2 got %h exp %h", r_rd2, e); end
        @(negedge clk); rst_n = 1'b1; rst_n6 = 1'b1;
    endtask

    task automatic test_defaults();
        @(negedge clk); we = 1'b1; wa = 3'd3; wd = 4'hA;
        @(negedge clk); we = 1'b0; ra1 = 3'd3; ra2 = 3'd3;
        exp_q.push_back(8'h0A); exp_q.push_back(8'h0A);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL def_rd1 got %h exp %h", rd1_d, e); end
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd2_d} !== e) begin errors++; $display("FAIL def_rd2 got %h exp %h", rd2_d, e); end
        checks++; if (written_d !== 8'b0000_1000) begin errors++; $display("FAIL def_written got %b exp 00001000", written_d); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk); we = 1'b1; wa = 3'd0; wd = 4'hF; ra1 = 3'd0;
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL zero_bypass got %h exp %h", rd1_d, e); end
        @(negedge clk); we = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h0F);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL zero_r0 got %h exp %h", rd1_d, e); end
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_a} !== e) begin errors++; $display("FAIL nozero_r0 got %h exp %h", rd1_a, e); end
        checks++; if (written_d !== 8'h08) begin errors++; $display("FAIL zero_written got %b exp 00001000", written_d); end
        checks++; if (written_a !== 8'h09) begin errors++; $display("FAIL nozero_written got %b exp 00001001", written_a); end
    endtask

    task automatic test_bypass();
        @(negedge clk); we = 1'b1; wa = 3'd5; wd = 4'h6; ra1 = 3'd5;
        exp_q.push_back(8'h06); exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL bypass_on got %h exp %h", rd1_d, e); end
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_a} !== e) begin errors++; $display("FAIL bypass_off got %h exp %h", rd1_a, e); end
        @(negedge clk); we = 1'b0;
        exp_q.push_back(8'h06);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_a} !== e) begin errors++; $display("FAIL bypass_off_next got %h exp %h", rd1_a, e); end
        checks++; if (written_d !== 8'h28) begin errors++; $display("FAIL bypass_written got %b exp 00101000", written_d); end
    endtask

    task automatic test_range_d6();
        @(negedge clk); we = 1'b1; wa = 3'd6; wd = 4'h3; ra1 = 3'd6; ra2 = 3'd7;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_6} !== e) begin errors++; $display("FAIL d6_rd_oor6 got %h exp %h", rd1_6, e); end
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd2_6} !== e) begin errors++; $display("FAIL d6_rd_oor7 got %h exp %h", rd2_6, e); end
        @(negedge clk); wa = 3'd7; wd = 4'h4; ra2 = 3'd7;
        @(negedge clk); we = 1'b0; ra1 = 3'd5;
        exp_q.push_back(8'h06);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_6} !== e) begin errors++; $display("FAIL d6_r5 got %h exp %h", rd1_6, e); end
        checks++; if (written_6 !== 6'b101000) begin errors++; $display("FAIL d6_written_oor got %b exp 101000", written_6); end
    endtask

    task automatic test_rd_reg();
        @(negedge clk); r_we = 1'b1; r_wa = 4'd9; r_wd = 8'h5C;
        @(negedge clk); r_we = 1'b0; r_ra2 = 4'd9;
        exp_q.push_back(8'h5C);
        #1;
        checks++; if (r_rd2 !== 8'h00) begin errors++; $display("FAIL rr_latency got %h exp 00", r_rd2); end
        @(negedge clk); #1;
        e = exp_q.pop_front();
        checks++; if (r_rd2 !== e) begin errors++; $display("FAIL rr_rd2 got %h exp %h", r_rd2, e); end
        @(negedge clk); r_we = 1'b1; r_wa = 4'd4; r_wd = 8'h77; r_ra1 = 4'd4;
        exp_q.push_back(8'h77);
        @(negedge clk); r_we = 1'b0; #1;
        e = exp_q.pop_front();
        checks++; if (r_rd1 !== e) begin errors++; $display("FAIL rr_bypass got %h exp %h", r_rd1, e); end
        checks++; if (r_written !== 16'h0210) begin errors++; $display("FAIL rr_written got %h exp 0210", r_written); end
        @(negedge clk); rst_n = 1'b0; #1;
        checks++; if (r_rd1 !== 8'h00 || r_rd2 !== 8'h00) begin errors++; $display("FAIL rr_reset got %h/%h exp 00/00", r_rd1, r_rd2); end
        checks++; if (r_written !== 16'h0000) begin errors++; $display("FAIL rr_reset_written got %h exp 0000", r_written); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_clear();
        int busy_cnt = 0;
        int first = 0;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk); we = 1'b1; wa = 3'(i); wd = 4'(i);
        end
        @(negedge clk); we = 1'b1; wa = 3'd2; wd = 4'h9; clr = 1'b1; ra1 = 3'd2;
        exp_q.push_back(8'h02);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL clr_no_bypass got %h exp %h", rd1_d, e); end
        checks++; if (written_d !== 8'hFE) begin errors++; $display("FAIL clr_filled got %b exp 11111110", written_d); end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin clr = 1'b0; we = 1'b0; ra1 = 3'd2; ra2 = 3'd6; end
            if (c == 3) ra1 = 3'd1;
            if (c == 4) clr = 1'b1;
            if (c == 5) clr = 1'b0;
            if (c == 8) begin we = 1'b1; wa = 3'd1; wd = 4'hF; end
            if (c == 9) we = 1'b0;
            #1;
            if (busy_d) begin busy_cnt++; if (first == 0) first = c; end
            if (c == 1) begin
                exp_q.push_back(8'h02); exp_q.push_back(8'h06);
                e = exp_q.pop_front();
                checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL clr_write_dropped got %h exp %h", rd1_d, e); end
                e = exp_q.pop_front();
                checks++; if ({4'h0, rd2_d} !== e) begin errors++; $display("FAIL clr_c1_r6 got %h exp %h", rd2_d, e); end
            end
            if (c == 3) begin
                exp_q.push_back(8'h00); exp_q.push_back(8'h06);
                e = exp_q.pop_front();
                checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL clr_mid_r1 got %h exp %h", rd1_d, e); end
                e = exp_q.pop_front();
                checks++; if ({4'h0, rd2_d} !== e) begin errors++; $display("FAIL clr_mid_r6 got %h exp %h", rd2_d, e); end
            end
            if (c == 8) begin
                checks++; if (rd1_d !== 4'h0) begin errors++; $display("FAIL clr_busy_bypass got %h exp 0", rd1_d); end
            end
        end
        checks++; if (busy_cnt != 8 || first != 1) begin errors++; $display("FAIL clr_busy_len got %0d from %0d exp 8 from 1", busy_cnt, first); end
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i);
            exp_q.push_back(8'h00);
            #1;
            e = exp_q.pop_front();
            checks++; if ({4'h0, rd1_d} !== e) begin errors++; $display("FAIL clr_after_r%0d got %h exp %h", i, rd1_d, e); end
        end
        checks++; if (written_d !== 8'h00) begin errors++; $display("FAIL clr_written got %b exp 00000000", written_d); end
    endtask

    task automatic test_reset_mid_sweep();
        int busy_cnt = 0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk); we = 1'b1; wa = 3'(i); wd = 4'(i);
        end
        @(negedge clk); we = 1'b0; #1;
        checks++; if (written_6 !== 6'b111110) begin errors++; $display("FAIL d6_filled got %b exp 111110", written_6); end
        @(negedge clk); clr = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clr = 1'b0; ra1 = 3'd4; ra2 = 3'd5;
            if (c == 3) rst_n6 = 1'b0;
            #1;
            if (c == 2) begin
                checks++; if (rd1_6 !== 4'h4 || busy_6 !== 1'b1) begin errors++; $display("FAIL d6_pre_reset got %h/%b exp 4/1", rd1_6, busy_6); end
            end
        end
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd1_6} !== e) begin errors++; $display("FAIL d6_rst_r4 got %h exp %h", rd1_6, e); end
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd2_6} !== e) begin errors++; $display("FAIL d6_rst_r5 got %h exp %h", rd2_6, e); end
        checks++; if (busy_6 !== 1'b0 || written_6 !== 6'h00) begin errors++; $display("FAIL d6_rst_state got %b/%b exp 0/000000", busy_6, written_6); end
        @(negedge clk); rst_n6 = 1'b1;
        repeat (8) @(negedge clk);
        we = 1'b1; wa = 3'd4; wd = 4'h7;
        @(negedge clk); we = 1'b0; clr = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk); clr = 1'b0; #1;
            if (busy_6) busy_cnt++;
        end
        checks++; if (busy_cnt != 6) begin errors++; $display("FAIL d6_sweep_len got %0d exp 6", busy_cnt); end
        ra1 = 3'd4; #1;
        checks++; if (rd1_6 !== 4'h0 || written_6 !== 6'h00) begin errors++; $display("FAIL d6_swept got %h/%b exp 0/000000", rd1_6, written_6); end
        @(negedge clk); we = 1'b1; wa = 3'd5; wd = 4'hC;
        @(negedge clk); we = 1'b0; ra2 = 3'd5;
        exp_q.push_back(8'h0C);
        #1;
        e = exp_q.pop_front();
        checks++; if ({4'h0, rd2_6} !== e) begin errors++; $display("FAIL d6_post_write got %h exp %h", rd2_6, e); end
        checks++; if (written_6 !== 6'b100000) begin errors++; $display("FAIL d6_post_written got %b exp 100000", written_6); end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_zero_reg();
        test_bypass();
        test_range_d6();
        test_rd_reg();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
